// File: rtl/chaotic_pkg.sv
// Shared fixed-point format of the Lorenz state and the packer FSM encoding.
package chaotic_pkg;

  localparam int integerBits  = 6;
  localparam int fractionBits = 25;
  localparam int totalBits    = 1 + integerBits + fractionBits;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

endpackage

// File: rtl/chaotic_keystream_packer_key_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is visible whenever non-empty.
// A write into a full FIFO is accepted only when a pop happens on the same edge.
module key_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_push;
  logic         w_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = i_rd && !o_empty;
  assign w_push  = i_wr && (!o_full || w_pop);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/chaotic_keystream_packer.sv
// Turns each Lorenz state update into an XOR key byte, packs bytes little-endian
// into words and streams them out of an FWFT FIFO as an AXI-Stream master.
module chaotic_keystream_packer
  import chaotic_pkg::*;
#(
  parameter int totalBits    = 1 + integerBits + fractionBits,
  parameter int extractBits  = 8,
  parameter int outBits      = 32,
  parameter int fifoDepth    = 8,
  parameter int discardCount = 16
) (
  input  logic                 clkSlow,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [totalBits-1:0] x0,
  input  logic [totalBits-1:0] y0,
  input  logic [totalBits-1:0] z0,
  output logic [outBits-1:0]   m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [15:0]          dropCount,
  output logic                 busy
);

  localparam int BytesPerWord = outBits / extractBits;
  localparam int CntW         = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;

  logic [totalBits-1:0]   r_x_prev;
  logic [totalBits-1:0]   r_y_prev;
  logic [totalBits-1:0]   r_z_prev;
  logic                   w_new_sample;
  logic [extractBits-1:0] w_key_byte;
  logic [outBits-1:0]     w_byte_ext;
  logic [outBits-1:0]     w_word;
  state_t                 r_state;
  state_t                 w_state_next;
  logic [15:0]            r_warm;
  logic [CntW-1:0]        r_cnt;
  logic [outBits-1:0]     r_shift;
  logic [15:0]            r_drop;
  logic                   w_accept;
  logic                   w_word_done;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic                   w_pop;
  logic [outBits-1:0]     w_fifo_rdata;

  assign w_new_sample = (x0 != r_x_prev) || (y0 != r_y_prev) || (z0 != r_z_prev);
  assign w_key_byte   = x0[extractBits-1:0] ^ y0[extractBits-1:0] ^ z0[extractBits-1:0];

  always_comb begin
    w_byte_ext                    = '0;
    w_byte_ext[extractBits-1:0]   = w_key_byte;
  end

  // The partial word is cleared on completion, so OR-ing the new byte into its lane suffices.
  assign w_word      = r_shift | (w_byte_ext << (r_cnt * extractBits));
  assign w_word_done = w_accept && (r_cnt == CntW'(BytesPerWord - 1));

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) w_state_next = (discardCount == 0) ? RUN : WARMUP;
      end
      WARMUP: begin
        if (!enable)                             w_state_next = IDLE;
        else if (w_new_sample && r_warm <= 16'd1) w_state_next = RUN;
      end
      RUN: begin
        if (!enable) w_state_next = IDLE;
        else         w_accept     = w_new_sample;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clkSlow or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clkSlow or negedge rst_n) begin
    if (!rst_n) begin
      r_x_prev <= '0;
      r_y_prev <= '0;
      r_z_prev <= '0;
      r_warm   <= '0;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_drop   <= '0;
    end else begin
      r_x_prev <= x0;
      r_y_prev <= y0;
      r_z_prev <= z0;

      if (r_state == IDLE && enable) begin
        r_warm <= 16'(discardCount);
      end else if (r_state == WARMUP && enable && w_new_sample && r_warm != 16'd0) begin
        r_warm <= r_warm - 1'b1;
      end

      if (!enable) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (w_accept) begin
        if (w_word_done) begin
          r_cnt   <= '0;
          r_shift <= '0;
        end else begin
          r_cnt   <= r_cnt + 1'b1;
          r_shift <= w_word;
        end
      end

      if (w_word_done && w_fifo_full && !w_pop && r_drop != 16'hFFFF) begin
        r_drop <= r_drop + 1'b1;
      end
    end
  end

  key_fifo #(
    .W     (outBits),
    .DEPTH (fifoDepth)
  ) u_key_fifo (
    .clk     (clkSlow),
    .rst_n   (rst_n),
    .i_wr    (w_word_done),
    .i_wdata (w_word),
    .i_rd    (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_pop     = !w_fifo_empty && m_tready;
  assign m_tvalid  = !w_fifo_empty;
  assign m_tdata   = w_fifo_empty ? '0 : w_fifo_rdata;
  assign dropCount = r_drop;
  assign busy      = (r_state != IDLE);

endmodule
